// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for a 5-stage RV32 pipeline.
// Selects the next PC (sequential or Execute redirect) and registers the fetched word for decode.
module fetch_stage #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_PC  = '0,
    parameter logic [WIDTH-1:0]   NOP_INSTR = WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrcE,
    input  logic [WIDTH-1:0] PCTargetE,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_ready,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCD,
    output logic [WIDTH-1:0] PCPlus4D,
    output logic             ValidD
);

    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    logic [WIDTH-1:0] pcf_q,      pcf_d;
    logic [WIDTH-1:0] instr_q,    instr_d;
    logic [WIDTH-1:0] pcd_q,      pcd_d;
    logic [WIDTH-1:0] pcplus4_q,  pcplus4_d;
    logic             valid_q,    valid_d;

    logic             fire;
    logic [WIDTH-1:0] pcf_plus4;

    assign fire      = imem_ready & ~StallF;
    assign pcf_plus4 = pcf_q + PC_STEP;
    assign imem_addr = pcf_q;

    // A redirect always lands, even while fetch is stalled or memory is busy,
    // so a taken branch can never be lost behind a hazard stall.
    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE) begin
            pcf_d = PCTargetE & ALIGN_MASK;
        end else if (fire) begin
            pcf_d = pcf_plus4;
        end
    end

    always_comb begin
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (FlushD) begin
            instr_d   = NOP_INSTR;
            pcd_d     = '0;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (!StallD) begin
            // A missed fetch still advances decode, carrying a tagged bubble at PCF.
            instr_d   = fire ? imem_rdata : NOP_INSTR;
            pcd_d     = pcf_q;
            pcplus4_d = pcf_plus4;
            valid_d   = fire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf_q     <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pcd_q     <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pcf_q     <= pcf_d;
            instr_q   <= instr_d;
            pcd_q     <= pcd_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcplus4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: instruction memory returns ~address, expectations are hand-computed.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int total;
    int bad;

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at address A is ~A (zero-cycle read).
    assign imem_rdata = ~imem_addr;

    typedef struct {
        logic        pcsrc;
        logic [31:0] target;
        logic        stallf;
        logic        stalld;
        logic        flushd;
        logic        ready;
        logic [31:0] exp_pcf;
        logic [31:0] exp_instr;
        logic [31:0] exp_pcd;
        logic [31:0] exp_pcp4;
        logic        exp_valid;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, idx, got, want);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [31:0] pcf, input logic [31:0] instr,
                             input logic [31:0] pcd, input logic [31:0] pcp4, input logic valid);
        check({tag, "_pcf"},   idx, imem_addr, pcf);
        check({tag, "_instr"}, idx, InstrD,    instr);
        check({tag, "_pcd"},   idx, PCD,       pcd);
        check({tag, "_pcp4"},  idx, PCPlus4D,  pcp4);
        check({tag, "_valid"}, idx, {31'b0, ValidD}, {31'b0, valid});
        $display("%s step=%0d pcf=%h instr=%h pcd=%h pcp4=%h valid=%0b",
                 tag, idx, imem_addr, InstrD, PCD, PCPlus4D, ValidD);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // pcsrc target        sF sD fD rdy  pcf           instr         pcd           pcp4          v
        vecs[0]  = '{0, 32'h0,          0, 0, 0, 1, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0004, 1};
        vecs[1]  = '{0, 32'h0,          0, 0, 0, 1, 32'h0000_0008, 32'hFFFF_FFFB, 32'h0000_0004, 32'h0000_0008, 1};
        vecs[2]  = '{0, 32'h0,          1, 1, 0, 1, 32'h0000_0008, 32'hFFFF_FFFB, 32'h0000_0004, 32'h0000_0008, 1};
        vecs[3]  = '{0, 32'h0,          1, 1, 0, 1, 32'h0000_0008, 32'hFFFF_FFFB, 32'h0000_0004, 32'h0000_0008, 1};
        vecs[4]  = '{0, 32'h0,          1, 1, 0, 1, 32'h0000_0008, 32'hFFFF_FFFB, 32'h0000_0004, 32'h0000_0008, 1};
        vecs[5]  = '{0, 32'h0,          0, 0, 0, 1, 32'h0000_000C, 32'hFFFF_FFF7, 32'h0000_0008, 32'h0000_000C, 1};
        vecs[6]  = '{0, 32'h0,          0, 0, 0, 0, 32'h0000_000C, 32'h0000_0013, 32'h0000_000C, 32'h0000_0010, 0};
        vecs[7]  = '{0, 32'h0,          0, 0, 0, 0, 32'h0000_000C, 32'h0000_0013, 32'h0000_000C, 32'h0000_0010, 0};
        vecs[8]  = '{0, 32'h0,          0, 0, 0, 1, 32'h0000_0010, 32'hFFFF_FFF3, 32'h0000_000C, 32'h0000_0010, 1};
        vecs[9]  = '{1, 32'h0000_0041,  0, 0, 1, 1, 32'h0000_0040, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[10] = '{0, 32'h0,          0, 0, 0, 1, 32'h0000_0044, 32'hFFFF_FFBF, 32'h0000_0040, 32'h0000_0044, 1};
        vecs[11] = '{0, 32'h0,          0, 1, 1, 1, 32'h0000_0048, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[12] = '{0, 32'h0,          1, 1, 0, 1, 32'h0000_0048, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[13] = '{1, 32'hFFFF_FFFE,  1, 1, 0, 0, 32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 0};
        vecs[14] = '{0, 32'h0,          0, 0, 0, 1, 32'h0000_0000, 32'h0000_0003, 32'hFFFF_FFFC, 32'h0000_0000, 1};
        vecs[15] = '{0, 32'h0,          0, 0, 0, 0, 32'h0000_0000, 32'h0000_0013, 32'h0000_0000, 32'h0000_0004, 0};
        vecs[16] = '{1, 32'h0000_0010,  0, 0, 0, 1, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0004, 1};

        rst        = 1'b1;
        PCSrcE     = 1'b0;
        PCTargetE  = '0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // The release edge above already fetched word@0; restart cleanly from reset.
        rst = 1'b1;
        #1;
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            PCSrcE     = vecs[i].pcsrc;
            PCTargetE  = vecs[i].target;
            StallF     = vecs[i].stallf;
            StallD     = vecs[i].stalld;
            FlushD     = vecs[i].flushd;
            imem_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            check_all("vec", i, vecs[i].exp_pcf, vecs[i].exp_instr, vecs[i].exp_pcd,
                      vecs[i].exp_pcp4, vecs[i].exp_valid);
        end

        // Asynchronous reset mid-cycle must act without a clock edge.
        PCSrcE     = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        imem_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_held", 0, 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst", 0, 32'h4, 32'hFFFF_FFFF, 32'h0, 32'h4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
